radix_2_div: RTL

//  Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU), the division counterpart of the MDU multiplier.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/radix_2_div.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU package: divider FSM state encoding, RISC-V M-extension
// divide/remainder type codes and the default operand width.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // div_type[0] = unsigned, div_type[1] = remainder
  localparam logic [1:0] DIV_T  = 2'b00;
  localparam logic [1:0] DIVU_T = 2'b01;
  localparam logic [1:0] REM_T  = 2'b10;
  localparam logic [1:0] REMU_T = 2'b11;

  typedef enum logic [2:0] {
    DIV_WAIT_VALID  = 3'd0,
    DIV_PRE_COMPUTE = 3'd1,
    DIV_COMPUTE     = 3'd2,
    DIV_POST        = 3'd3,
    DIV_DONE        = 3'd4
  } div_state_e;

endpackage

// File: rtl/radix_2_div.sv
// Iterative RISC-V divider (DIV/DIVU/REM/REMU).
// Restoring radix-2 division on operand magnitudes, one quotient bit per
// cycle, with the sign fix-up applied once at the end. Divide-by-zero and
// signed overflow short-circuit straight to the result.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   div_in_valid  request, only looked at while idle
//   div_type      [0]=unsigned, [1]=remainder
//   dividend      rs1, captured on the accept edge
//   divisor       rs2, captured on the accept edge
//   cpu_busy      CPU cannot take the result yet; holds the done state
//   div_out       registered quotient or remainder
//   div_out_valid high while the result is presented
//   div_busy      high whenever the unit is not idle
module radix_2_div
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_in_valid,
  input  logic [1:0]      div_type,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            cpu_busy,
  output logic [XLEN-1:0] div_out,
  output logic            div_out_valid,
  output logic            div_busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement magnitude; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic is_signed);
    logic signed [XLEN-1:0] neg_v;
    neg_v = -v;
    if (is_signed && v[XLEN-1]) return $unsigned(neg_v);
    return $unsigned(v);
  endfunction

  function automatic logic [XLEN-1:0] negate_if(input logic signed [XLEN-1:0] v,
                                                input logic neg);
    logic signed [XLEN-1:0] neg_v;
    neg_v = -v;
    return neg ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  div_state_e        state;
  logic [1:0]        type_r;
  logic [XLEN-1:0]   dividend_r;
  logic [XLEN-1:0]   divisor_r;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   q;
  logic [CNT_W-1:0]  cnt;

  logic              is_signed;
  logic              is_rem;
  logic              div_by_zero;
  logic              overflow;
  logic              q_neg;
  logic              r_neg;
  logic [XLEN-1:0]   dvnd_abs;
  logic [XLEN-1:0]   dvsr_abs;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   final_res;
  logic              rem_msb_unused;

  assign is_signed   = ~type_r[0];
  assign is_rem      = type_r[1];
  assign div_by_zero = (divisor_r == '0);
  assign overflow    = is_signed && (dividend_r == MIN_NEG) && (divisor_r == '1);

  // Quotient sign follows the operand sign mismatch; remainder follows the dividend.
  assign q_neg = is_signed & (dividend_r[XLEN-1] ^ divisor_r[XLEN-1]);
  assign r_neg = is_signed & dividend_r[XLEN-1];

  assign dvnd_abs = magnitude(dividend_r, is_signed);
  assign dvsr_abs = magnitude(divisor_r, is_signed);

  // One restoring step: bring down the next dividend bit, trial-subtract.
  assign shifted = {rem[XLEN-1:0], q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr_abs};

  // The partial remainder stays below the divisor, so its top bit never
  // carries information once a step has completed.
  assign rem_msb_unused = rem[XLEN];

  // divisor==0: quotient all-ones, remainder = dividend.
  // overflow:   quotient = dividend (MIN_NEG), remainder = 0.
  always_comb begin
    special_res = '0;
    if (div_by_zero) special_res = is_rem ? dividend_r : '1;
    else             special_res = is_rem ? '0 : dividend_r;
  end

  assign final_res = is_rem ? negate_if(rem[XLEN-1:0], r_neg) : negate_if(q, q_neg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= DIV_WAIT_VALID;
      type_r        <= '0;
      dividend_r    <= '0;
      divisor_r     <= '0;
      rem           <= '0;
      q             <= '0;
      cnt           <= '0;
      div_out       <= '0;
      div_out_valid <= 1'b0;
      div_busy      <= 1'b0;
    end else begin
      case (state)
        DIV_WAIT_VALID: begin
          if (div_in_valid) begin
            type_r     <= div_type;
            dividend_r <= dividend;
            divisor_r  <= divisor;
            div_busy   <= 1'b1;
            state      <= DIV_PRE_COMPUTE;
          end
        end

        DIV_PRE_COMPUTE: begin
          if (div_by_zero || overflow) begin
            div_out       <= special_res;
            div_out_valid <= 1'b1;
            state         <= DIV_DONE;
          end else begin
            q     <= dvnd_abs;
            rem   <= '0;
            cnt   <= '0;
            state <= DIV_COMPUTE;
          end
        end

        DIV_COMPUTE: begin
          if (!trial[XLEN]) begin
            rem <= trial;
            q   <= {q[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted;
            q   <= {q[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DIV_POST;
        end

        DIV_POST: begin
          div_out       <= final_res;
          div_out_valid <= 1'b1;
          state         <= DIV_DONE;
        end

        DIV_DONE: begin
          if (!cpu_busy) begin
            div_out_valid <= 1'b0;
            div_busy      <= 1'b0;
            state         <= DIV_WAIT_VALID;
          end
        end

        default: begin
          div_out_valid <= 1'b0;
          div_busy      <= 1'b0;
          state         <= DIV_WAIT_VALID;
        end
      endcase
    end
  end

endmodule
